// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave front end: synchronizes the pins into clk, shifts bytes in
// on sclk rise and out on sclk fall, and hands whole bytes to a register bridge.
module spi_slave_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       frame_start,
  output logic       frame_end,
  output logic       dbg_state
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   sclk_prev;
  logic                   armed;
  logic                   state;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic                   load_pend;

  logic s_sclk, s_mosi, s_cs_n, sclk_rise, sclk_fall;

  assign s_sclk    = sclk_sync[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync[SYNC_STAGES-1];
  assign s_cs_n    = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_prev;
  assign sclk_fall = ~s_sclk & sclk_prev;
  assign miso      = (state == ST_ACTIVE) & tx_shift[7];
  assign dbg_state = state;

  // fill marks when the synchronizers hold real pin values instead of reset
  // values; armed then requires a genuine high cs_n before any frame is taken.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      fill      <= '0;
      sclk_prev <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= s_sclk;
      armed     <= armed | (fill[SYNC_STAGES-1] & s_cs_n);
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      load_pend   <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed && !s_cs_n) begin
            state       <= ST_ACTIVE;
            frame_start <= 1'b1;
            tx_shift    <= tx_data;
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            load_pend   <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          // Deassert takes priority over any sclk edge seen in the same cycle.
          if (s_cs_n) begin
            state     <= ST_IDLE;
            frame_end <= 1'b1;
            bit_cnt   <= 3'd0;
            load_pend <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[6:0], s_mosi};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= {rx_shift[6:0], s_mosi};
                rx_valid  <= 1'b1;
                tx_req    <= 1'b1;
                load_pend <= 1'b1;
              end
            end
            if (sclk_fall) begin
              if (load_pend) begin
                tx_shift  <= tx_data;
                load_pend <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_phy.sv
// Bench for spi_slave_phy: a task-driven SPI master against a byte-level model
// of expected received bytes, miso bytes and strobe counts.
`timescale 1ns/1ps
module tb_spi_slave_phy;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       sclk, mosi, cs_n;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req, frame_start, frame_end;
  logic       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_rxv = 0, cnt_txr = 0, cnt_fs = 0, cnt_fe = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] miso_got[$];
  logic [7:0] miso_exp[$];

  spi_slave_phy #(.SYNC_STAGES(2)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .frame_start(frame_start), .frame_end(frame_end),
    .dbg_state(dbg_state)
  );

  // clock / reset block: 12 MHz
  always #41.667 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor, scoreboard and tx_req responder, sampled away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        cnt_rxv++;
        if (exp_q.size() > 0) check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
      if (tx_req) begin
        cnt_txr++;
        if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      end
      if (frame_start) cnt_fs++;
      if (frame_end) cnt_fe++;
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nbits, input int ph, output logic [7:0] m);
    m = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      #ph;
      sclk = 1'b1;
      m[i] = miso;
      #ph;
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int ph);
    logic [7:0] m;
    cs_n = 1'b0;
    #ph;
    for (int k = 0; k < mosi_q.size(); k++) begin
      send_bits(mosi_q[k], 8, ph, m);
      miso_got.push_back(m);
    end
    #ph;
    cs_n = 1'b1;
    #(2 * ph);
  endtask

  // Model: slave answers with first_tx, then each queued reply in order,
  // repeating the last presented value when replies run out.
  task automatic frame_test(input string name, input logic [7:0] first_tx, input int ph);
    logic [7:0] cur;
    int n, rxv0, txr0, fs0, fe0;
    n = mosi_q.size();
    cur = first_tx;
    for (int k = 0; k < n; k++) begin
      miso_exp.push_back(cur);
      if (k < tx_q.size()) cur = tx_q[k];
      exp_q.push_back(mosi_q[k]);
    end
    rxv0 = cnt_rxv; txr0 = cnt_txr; fs0 = cnt_fs; fe0 = cnt_fe;
    tx_data = first_tx;
    run_frame(ph);
    for (int k = 0; k < n; k++)
      check({name, "_miso"}, {24'h0, miso_got[k]}, {24'h0, miso_exp[k]});
    check({name, "_rx_valid_cnt"}, cnt_rxv - rxv0, n);
    check({name, "_tx_req_cnt"}, cnt_txr - txr0, n);
    check({name, "_frame_start_cnt"}, cnt_fs - fs0, 1);
    check({name, "_frame_end_cnt"}, cnt_fe - fe0, 1);
    check({name, "_sb_drained"}, exp_q.size(), 0);
    check({name, "_rx_hold"}, {24'h0, rx_data}, {24'h0, mosi_q[n-1]});
    mosi_q.delete(); miso_got.delete(); miso_exp.delete(); tx_q.delete(); exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_miso"}, miso, 0);
    check({name, "_rx_data"}, rx_data, 0);
    check({name, "_rx_valid"}, rx_valid, 0);
    check({name, "_tx_req"}, tx_req, 0);
    check({name, "_frame_start"}, frame_start, 0);
    check({name, "_frame_end"}, frame_end, 0);
    check({name, "_state"}, dbg_state, 0);
  endtask

  initial begin
    logic [7:0] m;
    int rxv0, txr0, fs0, fe0, n, ph;

    sys_rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; tx_data = 8'h00;
    #300;
    check_reset_outputs("reset");
    @(negedge clk); sys_rst_n = 1'b1;
    #500;

    // single byte
    mosi_q = '{8'hA5};
    frame_test("single", 8'h3C, 400);

    // multi-byte with replies
    mosi_q = '{8'h01, 8'hFF, 8'hFF};
    tx_q = '{8'h41, 8'h53};
    frame_test("multi", 8'h3C, 400);

    // partial byte is discarded, next frame starts clean
    rxv0 = cnt_rxv; txr0 = cnt_txr; fs0 = cnt_fs; fe0 = cnt_fe;
    tx_data = 8'h77;
    cs_n = 1'b0; #400;
    send_bits(8'hB6, 5, 400, m);
    #400; cs_n = 1'b1; #800;
    check("partial_rx_valid_cnt", cnt_rxv - rxv0, 0);
    check("partial_tx_req_cnt", cnt_txr - txr0, 0);
    check("partial_frame_start_cnt", cnt_fs - fs0, 1);
    check("partial_frame_end_cnt", cnt_fe - fe0, 1);
    check("partial_rx_hold", rx_data, 8'hFF);
    mosi_q = '{8'h81};
    frame_test("after_partial", 8'h96, 400);

    // idle noise
    rxv0 = cnt_rxv; txr0 = cnt_txr; fs0 = cnt_fs; fe0 = cnt_fe;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      #400;
      check("idle_miso", miso, 0);
    end
    check("idle_rx_valid_cnt", cnt_rxv - rxv0, 0);
    check("idle_tx_req_cnt", cnt_txr - txr0, 0);
    check("idle_frame_start_cnt", cnt_fs - fs0, 0);
    check("idle_frame_end_cnt", cnt_fe - fe0, 0);

    // reset mid-frame, released while cs_n still low
    tx_data = 8'hE7;
    cs_n = 1'b0; #400;
    send_bits(8'hC3, 3, 400, m);
    #($urandom_range(50, 200));
    sys_rst_n = 1'b0;
    #250;
    check_reset_outputs("midrst");
    #500;
    sys_rst_n = 1'b1;
    rxv0 = cnt_rxv; txr0 = cnt_txr; fs0 = cnt_fs; fe0 = cnt_fe;
    mosi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #400; sclk = 1'b1;
      check("midrst_miso", miso, 0);
      #400; sclk = 1'b0;
    end
    #400; cs_n = 1'b1; #800;
    check("midrst_rx_valid_cnt", cnt_rxv - rxv0, 0);
    check("midrst_tx_req_cnt", cnt_txr - txr0, 0);
    check("midrst_frame_start_cnt", cnt_fs - fs0, 0);
    check("midrst_frame_end_cnt", cnt_fe - fe0, 0);
    mosi_q = '{8'h5A};
    frame_test("after_rst", 8'h3C, 400);

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 3);
      ph = $urandom_range(350, 600);
      for (int k = 0; k < n; k++) begin
        mosi_q.push_back(8'($urandom));
        if (k > 0) tx_q.push_back(8'($urandom));
      end
      frame_test("rand", 8'($urandom), ph);
    end

    check("final_sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_phy.md
SPI_SLAVE_PHY -- requirements
Module: spi_slave_phy

Interface
REQ-001 SHALL have the following ports, with clock and reset first:
- clk  input  1  system clock, 12 MHz.
- sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-002 SHALL have the following SPI pins (mode 0, MSB first):
- sclk  input  1  SPI clock, asynchronous to clk.
- mosi  input  1  SPI data from master, asynchronous.
- cs_n  input  1  chip select, active-low, asynchronous.
- miso  output  1  SPI data to master.
REQ-003 SHALL have the following byte-side ports toward the register bridge:
- rx_data  output  8  last fully received byte.
- rx_valid  output  1  one-cycle strobe; rx_data is new.
- tx_data  input  8  next byte to shift out.
- tx_req  output  1  one-cycle strobe requesting the next tx_data.
- frame_start  output  1  one-cycle strobe on cs_n assertion.
- frame_end  output  1  one-cycle strobe on cs_n deassertion.
REQ-004 SHALL have one parameter: SYNC_STAGES, default 2, meaning the synchronizer depth for sclk, mosi and cs_n (minimum 2).

Function
REQ-005 SHALL pass sclk, mosi and cs_n through SYNC_STAGES flops in clk. Synchronizer reset values: sclk 0, mosi 0, cs_n 1.
REQ-006 SHALL detect SCLK rise and fall as a single-cycle compare of the synchronized sclk against its previous value.
REQ-007 SHALL implement two states:
- IDLE: synchronized cs_n = 1.
- ACTIVE: synchronized cs_n = 0.
- IDLE->ACTIVE when synchronized cs_n falls; ACTIVE->IDLE when it rises.
REQ-008 SHALL ignore all sclk edges while in IDLE: no bit counting, no shifting.
REQ-009 SHALL pulse frame_start in the IDLE->ACTIVE cycle, and in that same cycle:
- load the tx shift register from tx_data;
- clear the 3-bit bit counter;
- pulse tx_req nothing (no tx_req at frame start; tx_data must already be valid before cs_n falls).
REQ-010 SHALL, on each SCLK rise in ACTIVE, shift synchronized mosi into the rx shift register LSB side and increment the bit counter modulo 8.
REQ-011 SHALL, on the rise where the bit counter wraps 7->0:
- in the next cycle, update rx_data with the full byte (first received bit = bit 7);
- in that same next cycle, pulse rx_valid and tx_req together.
REQ-012 SHALL, on each SCLK fall in ACTIVE:
- if the fall follows a byte-completing rise, load the tx shift register from tx_data;
- otherwise, shift the tx shift register left by one.
REQ-013 SHALL drive miso from the tx shift register MSB in ACTIVE, and 0 in IDLE.
REQ-014 SHALL require the consumer to hold tx_data stable from 1 cycle after tx_req until the next SCLK fall. With sclk phases >= 4 clk periods, this SHALL always be met.
REQ-015 SHALL pulse frame_end in the ACTIVE->IDLE cycle and clear the bit counter. A partial byte (fewer than 8 rises) SHALL be discarded: no rx_valid, rx_data unchanged.
REQ-016 SHALL handle an sclk edge detected in the same cycle as the cs_n deassert by ignoring it (deassert wins).
REQ-017 SHALL handle a cs_n re-assert after frame_end like a fresh frame (REQ-009), with no state carried over.
REQ-018 SHALL hold rx_data until the next completed byte; it SHALL NOT be cleared by frame_end.
REQ-019 SHALL require the minimum supported sclk high and low time to be 4 clk periods; faster sclk is out of scope.

Reset
REQ-020 SHALL, while sys_rst_n = 0 (asynchronously), force:
- state IDLE;
- miso 0, rx_data 8'h00, rx_valid 0, tx_req 0, frame_start 0, frame_end 0;
- shift registers and bit counter 0;
- synchronizers to REQ-005 values.
REQ-021 SHALL treat reset asserted mid-frame as abort: after release, wait for synchronized cs_n high before any new frame is recognized.
REQ-022 SHALL NOT report frame_start on release if cs_n is still low at release.

Verification
REQ-023 Single byte: tx_data=8'h3C, cs_n low, master sends 8'hA5 (400 ns phases) -> exactly one rx_valid with rx_data=8'hA5; master samples miso 0,0,1,1,1,1,0,0; one frame_start, one frame_end.
REQ-024 Multi-byte: master sends 8'h01,8'hFF,8'hFF; bench answers each tx_req with 8'h41 then 8'h53 -> rx_data sequence 01,FF,FF; master receives 3C,41,53; three tx_req pulses.
REQ-025 Partial byte: 5 sclk cycles then cs_n high, then new frame sending 8'h81 -> no rx_valid for the partial byte; next rx_valid gives 8'h81.
REQ-026 Idle noise: 16 sclk toggles with cs_n high -> no rx_valid, tx_req or frame strobes; miso stays 0.
REQ-027 Reset mid-frame: sys_rst_n low after 3 bits of 8'hC3, released with cs_n low, 5 more clocks, cs_n high, then full 8'h5A frame -> all outputs at reset values during reset; no strobes until the new frame; then rx_data=8'h5A.
